scroll_scheduler: RTL and testbench
===================================

SCROLL_SCHEDULER -- requirements
Module: scroll_scheduler

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 25000: clk cycles per digit slot, minimum 2.
REQ-002 SHALL have parameter STEP_DIV, default 25000000: clk cycles per auto-rotate step, minimum 2.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-005 mode_btn  in  1  raw, asynchronous mode-cycle request; already debounced externally.
REQ-006 step_btn  in  1  raw, asynchronous manual-step request; already debounced externally.
REQ-007 dir  in  1  rotate direction: 0 = pointer+1, 1 = pointer-1; synchronous level.
REQ-008 wr_en  in  1  message-memory write strobe.
REQ-009 wr_addr  in  4  message-memory write address.
REQ-010 wr_data  in  4  message-memory write data.
REQ-011 an  out  4  anode enables {an3,an2,an1,an0}, active-low, exactly one low at all times.
REQ-012 char  out  4  code for the active digit, fed to the external LED decoder.
REQ-013 pointer  out  4  message index shown on an3.
REQ-014 state  out  2  FSM state: 00 AUTO, 01 PAUSE, 10 MANUAL.

Function
REQ-015 Message memory SHALL be 16 x 4 bits, written on the clk edge where wr_en=1; writes are honoured in every state.
REQ-016 Scan counter SHALL count 0..SCAN_DIV-1; at terminal count the active digit advances an3 -> an2 -> an1 -> an0 -> an3.
REQ-017 Digit mapping SHALL be an3 = msg[pointer], an2 = msg[pointer+1], an1 = msg[pointer+2], an0 = msg[pointer+3], with mod-16 addition.
REQ-018 an and char SHALL be registered and change on the same clk edge.
REQ-019 char SHALL be re-read every cycle: a write to the displayed address appears on char one cycle after the write edge.
REQ-020 The pointer SHALL wrap 15 -> 0 when dir=0 and 0 -> 15 when dir=1.
REQ-021 Each button SHALL pass through a 2-flop synchroniser and a rising-edge detector producing a 1-cycle pulse; action occurs 3 clk edges after the input rises.
REQ-022 In AUTO, the step counter SHALL count 0..STEP_DIV-1; at terminal count it reloads to 0 and the pointer moves one position per dir.
REQ-023 In PAUSE, the step counter and pointer SHALL hold.
REQ-024 In MANUAL, each step pulse SHALL move the pointer exactly one position per dir; the step counter holds.
REQ-025 Step pulses outside MANUAL SHALL be ignored.
REQ-026 A mode pulse SHALL transition AUTO -> PAUSE -> MANUAL -> AUTO.
REQ-027 The step counter SHALL clear to 0 on entry to AUTO.
REQ-028 If a mode pulse coincides with an auto terminal count or a step pulse, the transition SHALL win and the pointer SHALL hold that cycle.
REQ-029 The scan counter SHALL run in all states, independent of mode.

Reset
REQ-030 While reset=0: an=0111, char=0, pointer=0, state=AUTO, scan and step counters 0, synchroniser and edge flops 0.
REQ-031 While reset=0, msg[i]=i for i=0..15.
REQ-032 Reset asserted mid-operation SHALL abort any step or write in flight; no partial update survives.
REQ-033 The first digit advance SHALL occur SCAN_DIV edges after reset deasserts.

Structure
REQ-034 Shared package disp_pkg SHALL hold the state encodings, NUM_DIGITS=4, MSG_DEPTH=16, ANODE_RESET=4'b0111.
REQ-035 A sub-module btn_sync_edge (2-flop synchroniser plus rising-edge pulse) SHALL be instantiated once per button; the rest stays in scroll_scheduler.

Verification (SCAN_DIV=4, STEP_DIV=16)
REQ-036 Release reset, idle inputs -> an cycles 0111, 1011, 1101, 1110 every 4 clk with char 0, 1, 2, 3; at clk 16 pointer=1 and chars become 1, 2, 3, 4.
REQ-037 dir=1 from reset -> at clk 16 pointer=F; an3 shows F, an0 shows 2.
REQ-038 mode pulse -> state=01 and pointer held for 64 clk; second pulse -> state=10; step pulse -> pointer+1 exactly 3 edges after the rise; third mode pulse -> state=00.
REQ-039 With pointer=0 and an1 active, write wr_addr=2, wr_data=A -> char=A on the next edge; a reset then restores msg[2]=2.
REQ-040 In MANUAL, mode and step rising edges in the same cycle -> state=00, pointer unchanged.
REQ-041 Drop reset mid-slot with pointer=7 in MANUAL -> immediately an=0111, char=0, pointer=0, state=00.

Source files
------------

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_pkg
// Purpose  : Shared constants, state encodings and anode helper for the
//            scrolling four-digit message display.
// Revision : 1.0 - initial release
// ============================================================================
package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int MSG_DEPTH  = 16;
  localparam int DIGIT_W    = $clog2(NUM_DIGITS);
  localparam int ADDR_W     = $clog2(MSG_DEPTH);
  localparam int CHAR_W     = 4;

  localparam logic [NUM_DIGITS-1:0] ANODE_RESET = 4'b0111;

  typedef enum logic [1:0] {
    ST_AUTO   = 2'b00,
    ST_PAUSE  = 2'b01,
    ST_MANUAL = 2'b10
  } disp_state_t;

  // Digit slot 0 drives an3 (leftmost); anodes are one-cold.
  function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [DIGIT_W-1:0] digit);
    logic [NUM_DIGITS-1:0] onehot;
    onehot = {1'b1, {(NUM_DIGITS-1){1'b0}}} >> digit;
    return ~onehot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_sync_edge
// Purpose  : Two-flop synchroniser for a raw button level followed by a
//            rising-edge detector giving a single-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronise the raw input and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Both terms are flop outputs, so the pulse is glitch-free and one cycle long.
  assign pulse = sync2 & ~prev;

endmodule
`default_nettype wire

// File: rtl/scroll_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : scroll_scheduler
// Purpose  : Multiplexes a 16-entry message window onto four active-low
//            digits and scrolls the window automatically, manually or not
//            at all, selected by a mode button.
// Revision : 1.0 - initial release
// ============================================================================
module scroll_scheduler
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 25000,
  parameter int STEP_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode_btn,
  input  logic                  step_btn,
  input  logic                  dir,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [CHAR_W-1:0]     wr_data,
  output logic [NUM_DIGITS-1:0] an,
  output logic [CHAR_W-1:0]     char,
  output logic [ADDR_W-1:0]     pointer,
  output logic [1:0]            state
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int STEP_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  logic                  mode_pulse;
  logic                  step_pulse;

  logic [CHAR_W-1:0]     msg [MSG_DEPTH];
  logic [SCAN_W-1:0]     scan_cnt;
  logic [STEP_W-1:0]     step_cnt;
  logic [DIGIT_W-1:0]    digit;
  disp_state_t           state_reg;

  logic                  scan_last;
  logic                  step_last;
  logic [DIGIT_W-1:0]    digit_next;
  logic [ADDR_W-1:0]     pointer_moved;
  logic [ADDR_W-1:0]     pointer_next;
  logic [ADDR_W-1:0]     char_addr;
  logic [STEP_W-1:0]     step_cnt_next;
  disp_state_t           state_next;

  btn_sync_edge u_mode_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (mode_btn),
    .pulse (mode_pulse)
  );

  btn_sync_edge u_step_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  assign state = state_reg;

  // Next digit slot, scroll FSM and pointer movement; a mode pulse always wins.
  always_comb begin
    scan_last     = (scan_cnt == SCAN_LAST);
    step_last     = (step_cnt == STEP_LAST);
    digit_next    = scan_last ? digit + DIGIT_W'(1) : digit;
    pointer_moved = dir ? pointer - ADDR_W'(1) : pointer + ADDR_W'(1);
    state_next    = state_reg;
    pointer_next  = pointer;
    step_cnt_next = step_cnt;

    case (state_reg)
      ST_AUTO: begin
        if (mode_pulse) begin
          state_next = ST_PAUSE;
        end else if (step_last) begin
          step_cnt_next = '0;
          pointer_next  = pointer_moved;
        end else begin
          step_cnt_next = step_cnt + STEP_W'(1);
        end
      end
      ST_PAUSE: begin
        if (mode_pulse) begin
          state_next = ST_MANUAL;
        end
      end
      ST_MANUAL: begin
        if (mode_pulse) begin
          state_next    = ST_AUTO;
          step_cnt_next = '0;
        end else if (step_pulse) begin
          pointer_next = pointer_moved;
        end
      end
      default: begin
        state_next    = ST_AUTO;
        step_cnt_next = '0;
      end
    endcase

    // Look up the character for the slot and window that will be live after this edge.
    char_addr = pointer_next + ADDR_W'(digit_next);
  end

  // Message memory: reset loads an identity pattern, writes accepted in any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        msg[i] <= CHAR_W'(i);
      end
    end else if (wr_en) begin
      msg[wr_addr] <= wr_data;
    end
  end

  // Scan and step counters, FSM state, pointer and the registered digit drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      step_cnt  <= '0;
      digit     <= '0;
      state_reg <= ST_AUTO;
      pointer   <= '0;
      an        <= ANODE_RESET;
      char      <= '0;
    end else begin
      scan_cnt  <= scan_last ? '0 : scan_cnt + SCAN_W'(1);
      step_cnt  <= step_cnt_next;
      digit     <= digit_next;
      state_reg <= state_next;
      pointer   <= pointer_next;
      an        <= anode_for(digit_next);
      char      <= msg[char_addr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scroll_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_scroll_scheduler
// Purpose  : Directed scoreboard bench for scroll_scheduler with
//            SCAN_DIV=4 and STEP_DIV=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scroll_scheduler;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       mode_btn = 1'b0;
  logic       step_btn = 1'b0;
  logic       dir      = 1'b0;
  logic       wr_en    = 1'b0;
  logic [3:0] wr_addr  = 4'h0;
  logic [3:0] wr_data  = 4'h0;
  logic [3:0] an;
  logic [3:0] ch;
  logic [3:0] pointer;
  logic [1:0] state;

  int cyc      = 0;
  int base     = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] an;
    logic [3:0] ch;
    logic [3:0] ptr;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];

  scroll_scheduler #(
    .SCAN_DIV (4),
    .STEP_DIV (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode_btn (mode_btn),
    .step_btn (step_btn),
    .dir      (dir),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .an       (an),
    .char     (ch),
    .pointer  (pointer),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Edge counter: value k after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_abs(input int c, input string n, input logic [3:0] a,
                          input logic [3:0] chv, input logic [3:0] p, input logic [1:0] s);
    exp_t e;
    e.cyc = c; e.name = n; e.an = a; e.ch = chv; e.ptr = p; e.st = s;
    sb.push_back(e);
  endtask

  // Expectation k edges after the current reset release.
  task automatic expect_at(input int k, input string n, input logic [3:0] a,
                           input logic [3:0] chv, input logic [3:0] p, input logic [1:0] s);
    push_abs(base + k, n, a, chv, p, s);
  endtask

  task automatic at_cyc(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic do_reset(input logic d);
    @(negedge clk);
    reset = 1'b0; mode_btn = 1'b0; step_btn = 1'b0; wr_en = 1'b0; dir = d;
    repeat (3) @(negedge clk);
    push_abs(cyc + 1, "reset_state", 4'b0111, 4'h0, 4'h0, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    base  = cyc;
  endtask

  // Monitor: after each edge, pop and compare every expectation due by now.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          failures++;
          $display("FAIL %s: due at edge %0d, not checked until edge %0d", e.name, e.cyc, cyc);
        end else if ({an, ch, pointer, state} !== {e.an, e.ch, e.ptr, e.st}) begin
          failures++;
          $display("FAIL %s: got an=%b char=%h pointer=%h state=%b, expected an=%b char=%h pointer=%h state=%b",
                   e.name, an, ch, pointer, state, e.an, e.ch, e.ptr, e.st);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Idle scan and first auto step, dir=0.
    do_reset(1'b0);
    expect_at( 4, "t1_an2",        4'b1011, 4'h1, 4'h0, 2'b00);
    expect_at( 8, "t1_an1",        4'b1101, 4'h2, 4'h0, 2'b00);
    expect_at(12, "t1_an0",        4'b1110, 4'h3, 4'h0, 2'b00);
    expect_at(15, "t1_pre_step",   4'b1110, 4'h3, 4'h0, 2'b00);
    expect_at(16, "t1_step_an3",   4'b0111, 4'h1, 4'h1, 2'b00);
    expect_at(20, "t1_step_an2",   4'b1011, 4'h2, 4'h1, 2'b00);
    expect_at(24, "t1_step_an1",   4'b1101, 4'h3, 4'h1, 2'b00);
    expect_at(28, "t1_step_an0",   4'b1110, 4'h4, 4'h1, 2'b00);
    at_cyc(29);

    // Reverse direction wraps 0 -> F.
    do_reset(1'b1);
    expect_at(16, "t2_wrap_an3",   4'b0111, 4'hF, 4'hF, 2'b00);
    expect_at(28, "t2_wrap_an0",   4'b1110, 4'h2, 4'hF, 2'b00);
    expect_at(32, "t2_second",     4'b0111, 4'hE, 4'hE, 2'b00);
    at_cyc(33);

    // Mode cycling, pause hold, ignored step, manual step, counter clear on AUTO.
    do_reset(1'b0);
    expect_at(  5, "t3_pause",       4'b1011, 4'h1, 4'h0, 2'b01);
    expect_at( 69, "t3_pause_hold",  4'b1011, 4'h1, 4'h0, 2'b01);
    expect_at( 73, "t3_manual",      4'b1101, 4'h2, 4'h0, 2'b10);
    expect_at( 78, "t3_pre_mstep",   4'b1110, 4'h3, 4'h0, 2'b10);
    expect_at( 79, "t3_mstep",       4'b1110, 4'h4, 4'h1, 2'b10);
    expect_at( 85, "t3_auto",        4'b1011, 4'h2, 4'h1, 2'b00);
    expect_at(100, "t3_auto_pre",    4'b1011, 4'h2, 4'h1, 2'b00);
    expect_at(101, "t3_auto_step",   4'b1011, 4'h3, 4'h2, 2'b00);
    at_cyc(2);   mode_btn = 1'b1;
    at_cyc(6);   mode_btn = 1'b0;
    at_cyc(30);  step_btn = 1'b1;
    at_cyc(34);  step_btn = 1'b0;
    at_cyc(70);  mode_btn = 1'b1;
    at_cyc(74);  mode_btn = 1'b0;
    at_cyc(76);  step_btn = 1'b1;
    at_cyc(80);  step_btn = 1'b0;
    at_cyc(82);  mode_btn = 1'b1;
    at_cyc(86);  mode_btn = 1'b0;
    at_cyc(102);

    // Write to the displayed address, then reset restores the identity pattern.
    do_reset(1'b0);
    expect_at( 9, "t4_pre_write",  4'b1101, 4'h2, 4'h0, 2'b00);
    expect_at(10, "t4_write_seen", 4'b1101, 4'hA, 4'h0, 2'b00);
    at_cyc(8);   wr_en = 1'b1; wr_addr = 4'h2; wr_data = 4'hA;
    at_cyc(9);   wr_en = 1'b0;
    at_cyc(11);
    do_reset(1'b0);
    expect_at( 8, "t4_restored",   4'b1101, 4'h2, 4'h0, 2'b00);
    at_cyc(9);

    // Simultaneous mode and step in MANUAL: transition wins, pointer holds.
    do_reset(1'b0);
    expect_at( 9, "t5_manual",     4'b1101, 4'h2, 4'h0, 2'b10);
    expect_at(15, "t5_collide",    4'b1110, 4'h3, 4'h0, 2'b00);
    expect_at(30, "t5_auto_pre",   4'b1110, 4'h3, 4'h0, 2'b00);
    expect_at(31, "t5_auto_step",  4'b1110, 4'h4, 4'h1, 2'b00);
    mode_btn = 1'b1;
    at_cyc(4);   mode_btn = 1'b0;
    at_cyc(6);   mode_btn = 1'b1;
    at_cyc(10);  mode_btn = 1'b0;
    at_cyc(12);  mode_btn = 1'b1; step_btn = 1'b1;
    at_cyc(16);  mode_btn = 1'b0; step_btn = 1'b0;
    at_cyc(32);

    // Seven manual steps to pointer 7, then asynchronous reset mid-slot.
    do_reset(1'b0);
    expect_at(40, "t6_ptr7",       4'b1101, 4'h9, 4'h7, 2'b10);
    expect_at(41, "t6_async_rst",  4'b0111, 4'h0, 4'h0, 2'b00);
    mode_btn = 1'b1;
    at_cyc(4);   mode_btn = 1'b0;
    at_cyc(6);   mode_btn = 1'b1;
    at_cyc(10);  mode_btn = 1'b0;
    for (int k = 0; k < 7; k++) begin
      at_cyc(12 + 4 * k); step_btn = 1'b1;
      at_cyc(14 + 4 * k); step_btn = 1'b0;
    end
    at_cyc(40);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover: %0d expectations never checked, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
